uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1 UART transmitter; the transmit-side counterpart of the board's UART receive path.
- Lets the CPU or any producer return bytes to the host PC, for example acknowledgements of the U/D/L/R (0x55/0x44/0x4C/0x52) command bytes.
- A small FIFO buffers incoming bytes. The producer pushes with a valid/ready handshake, and the block serializes the bytes onto the `tx` pin, LSB first.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- FIFO_DEPTH, 4, byte buffer depth. Must be a power of 2 and ≥ 2.
- Derived: CLKS_PER_BIT = CLK_FREQ / BAUD, using integer division (truncating). This is 434 at the defaults.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- data  input  8  byte to transmit.
- valid  input  1  producer has a byte on `data`.
- ready  output  1  FIFO can accept a byte; a push happens when valid && ready at a rising edge.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in flight or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.

Behaviour:
- Reset (rst=0, takes effect immediately without waiting for a clock edge):
  - tx=1, ready=1, busy=0, fifo_count=0.
  - FIFO pointers cleared; FSM in IDLE; bit/baud counters zeroed.
  - Reset in the middle of a frame aborts it; tx returns to 1 at once. Partial frames are never resumed.
- FIFO:
  - ready = (fifo_count != FIFO_DEPTH), decoded combinationally from registered state.
  - When full, there is no bypass: a push is refused even in a cycle where the FSM pops.
  - Push and pop in the same cycle with the FIFO not full: count is unchanged, data order is preserved.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - `data` is ignored when valid=0 or ready=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1.
    - If fifo_count>0 at a rising edge: pop the head byte into the shift register, enter START, baud counter = 0.
    - Latency: a byte accepted into an empty FIFO at edge N is popped at edge N+1, so tx falls after edge N+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7 (LSB first). After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On its last cycle:
    - if fifo_count>0, pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx is driven from a register (glitch-free); it changes only on rising clk edges or on reset.
- busy = (state != IDLE) || (fifo_count != 0), registered-state derived.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
- No parity bit, no break generation, and no flow-control pins.

Test Plan:
- Single byte, CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10): push 0x55 once → tx falls 1 cycle after the accepting edge. tx then holds, 10 cycles each, the values 0 | 1,0,1,0,1,0,1,0 | 1. busy drops in the cycle after the stop bit ends. Total frame = 100 cycles.
- Back-to-back: push 0x44, 0x4C, 0x52 on consecutive cycles → three contiguous frames, 300 cycles total with no idle-high gap between stop and start. Decoded bytes must match and appear in order.
- FIFO full, depth 4: assert valid for 6 consecutive cycles (bytes 0x01..0x06).
  - 0x01 is popped immediately.
  - 0x02..0x05 fill the FIFO; fifo_count reaches 4 and ready drops.
  - 0x06 stalls until the first pop at the end of the 0x01 frame, then is accepted.
  - All 6 bytes are transmitted in order.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0xA7 with 2 bytes queued → tx=1, busy=0, fifo_count=0 immediately. After release, no transmission until a new push.
- Loopback: connect tx to the board's UART receiver at default parameters and send 0x00, 0xFF, 0x5A, 0x80 → the receiver reports the same four bytes with one valid pulse each.
- Idle stability: no pushes for 10000 cycles after reset → tx remains 1, ready remains 1, busy remains 0.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// Bytes go out LSB first; frames run back to back while the FIFO has data.
module uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data,
    input  logic                        valid,
    output logic                        ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic push, pop, has_data, baud_last;

    assign ready      = (count != FULL);
    assign push       = valid && ready;
    assign has_data   = (count != '0);
    assign baud_last  = (baud_cnt == BAUD_LAST);
    assign tx         = tx_q;
    assign busy       = (state != IDLE) || has_data;
    assign fifo_count = count;

    // Storage needs no reset; occupancy is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx_q;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (has_data) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    baud_n  = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                    tx_n    = shift[0];
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = shift[bit_idx + 3'd1];
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when data waits.
                    if (has_data) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit with a 4-deep FIFO.
// Frames are compared cycle by cycle against hand-written bit patterns.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, output int waited);
        waited = 0;
        data   = d;
        valid  = 1'b1;
        @(negedge clk);
        while (ready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 400) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: byte %0h got no ready in %0d cycles",
                     d, waited);
        end
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    // Called just after the edge on which the start bit should begin.
    task automatic check_frame(input int idx);
        logic [7:0] rx;
        logic       bad;
        rx = 8'h00;
        for (int i = 0; i < 10; i++) begin
            bad = 1'b0;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (tx !== vecs[idx].frame[i]) bad = 1'b1;
                if (j == 4 && i >= 1 && i <= 8) rx[i-1] = tx;
            end
            check($sformatf("frame%0d_bit%0d_mismatch", idx, i), bad, 0);
        end
        check($sformatf("frame%0d_rx_byte", idx), rx, vecs[idx].d);
        check($sformatf("frame%0d_busy_in_stop", idx), busy, 1);
    endtask

    // Started in the same cycle as the first push.
    task automatic run_frames(input int first, input int n);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("latency_tx_high_%0d", first), tx, 1);
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            check_frame(first + k);
            if (k < n - 1) @(posedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check($sformatf("after_%0d_busy", first), busy, 0);
        check($sformatf("after_%0d_tx", first), tx, 1);
        check($sformatf("after_%0d_count", first), fifo_count, 0);
        check($sformatf("after_%0d_ready", first), ready, 1);
    endtask

    int w;
    int w6;
    int list [5];
    logic bad_tx, bad_rdy, bad_busy;

    initial begin
        vecs[0]  = '{8'h55, 10'b1010101010};
        vecs[1]  = '{8'h44, 10'b1010001000};
        vecs[2]  = '{8'h4C, 10'b1010011000};
        vecs[3]  = '{8'h52, 10'b1010100100};
        vecs[4]  = '{8'h01, 10'b1000000010};
        vecs[5]  = '{8'h02, 10'b1000000100};
        vecs[6]  = '{8'h03, 10'b1000000110};
        vecs[7]  = '{8'h04, 10'b1000001000};
        vecs[8]  = '{8'h05, 10'b1000001010};
        vecs[9]  = '{8'h06, 10'b1000001100};
        vecs[10] = '{8'hA7, 10'b1101001110};
        vecs[11] = '{8'h00, 10'b1000000000};
        vecs[12] = '{8'hFF, 10'b1111111110};
        vecs[13] = '{8'h5A, 10'b1010110100};
        vecs[14] = '{8'h80, 10'b1100000000};
        list = '{0, 11, 12, 13, 14};

        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("reset_tx", tx, 1);
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_count", fifo_count, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        bad_tx = 1'b0;
        bad_rdy = 1'b0;
        bad_busy = 1'b0;
        repeat (10000) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1'b1;
            if (ready !== 1'b1) bad_rdy = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        check("idle_tx_dropped", bad_tx, 0);
        check("idle_ready_dropped", bad_rdy, 0);
        check("idle_busy_raised", bad_busy, 0);

        @(posedge clk);
        #1;
        fork
            push(vecs[0].d, w);
            run_frames(0, 1);
        join

        @(posedge clk);
        #1;
        fork
            begin
                push(vecs[1].d, w);
                push(vecs[2].d, w);
                push(vecs[3].d, w);
            end
            run_frames(1, 3);
        join

        @(posedge clk);
        #1;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    push(vecs[4 + k].d, w);
                    check($sformatf("fill_wait_%0d", k), w, 0);
                end
                check("full_count", fifo_count, 4);
                check("full_ready", ready, 0);
                push(vecs[9].d, w6);
            end
            run_frames(4, 6);
        join
        check("full_stall_cycles", w6, 97);

        @(posedge clk);
        #1;
        push(vecs[10].d, w);
        push(8'h11, w);
        push(8'h22, w);
        repeat (44) @(negedge clk);
        check("midframe_tx_bit3", tx, 0);
        check("midframe_count", fifo_count, 2);
        check("midframe_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_count", fifo_count, 0);
        check("abort_ready", ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad_tx = 1'b0;
        bad_busy = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        check("post_abort_tx_moved", bad_tx, 0);
        check("post_abort_busy", bad_busy, 0);

        for (int i = 1; i < 5; i++) begin
            @(posedge clk);
            #1;
            fork
                push(vecs[list[i]].d, w);
                run_frames(list[i], 1);
            join
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
